// File: rtl/vga_controller.sv
`default_nettype none
// ============================================================================
// vga_controller: 640x480@60 raster timing, colour capture/blanking, frame tick.
// Optional frame counter: VGA_FRAME_COUNT_EN.  Rev 1.0
// ============================================================================
module vga_controller #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int COLOR_LATENCY = 0
) (
  input  logic        CLOCK_25,
  input  logic        RESET,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        active,
  input  logic [2:0]  color,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        frame_tick
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] c_H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] c_V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] c_H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] c_V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] c_HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] c_HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] c_VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] c_VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] c_V_TICK_PRE = 12'(V_ACTIVE - 1);

  logic [11:0] r_hc;
  logic [11:0] r_vc;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_active;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_tick_next;
  logic        w_act_d;
  logic        w_hs_d;
  logic        w_vs_d;

  assign w_h_wrap = (r_hc == c_H_LAST);
  assign w_v_wrap = (r_vc == c_V_LAST);

  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_h_wrap) begin
      r_hc <= '0;
      r_vc <= w_v_wrap ? 12'd0 : r_vc + 12'd1;
    end else begin
      r_hc <= r_hc + 12'd1;
    end
  end

  assign x        = r_hc;
  assign y        = r_vc;
  assign w_active = (r_hc < c_H_ACT) && (r_vc < c_V_ACT);
  assign active   = w_active;
  assign w_hs_raw = !((r_hc >= c_HS_START) && (r_hc <= c_HS_END));
  assign w_vs_raw = !((r_vc >= c_VS_START) && (r_vc <= c_VS_END));

  // Tick is registered on the edge that moves the counters to (0, V_ACTIVE).
  assign w_tick_next = w_h_wrap && (r_vc == c_V_TICK_PRE);

  generate
    if (COLOR_LATENCY == 0) begin : g_no_delay
      assign w_act_d = w_active;
      assign w_hs_d  = w_hs_raw;
      assign w_vs_d  = w_vs_raw;
    end else begin : g_delay
      logic [COLOR_LATENCY-1:0] r_act_pipe;
      logic [COLOR_LATENCY-1:0] r_hs_pipe;
      logic [COLOR_LATENCY-1:0] r_vs_pipe;

      always_ff @(posedge CLOCK_25 or posedge RESET) begin
        if (RESET) begin
          r_act_pipe <= '0;
          r_hs_pipe  <= '1;
          r_vs_pipe  <= '1;
        end else begin
          r_act_pipe[0] <= w_active;
          r_hs_pipe[0]  <= w_hs_raw;
          r_vs_pipe[0]  <= w_vs_raw;
          for (int i = 1; i < COLOR_LATENCY; i++) begin
            r_act_pipe[i] <= r_act_pipe[i-1];
            r_hs_pipe[i]  <= r_hs_pipe[i-1];
            r_vs_pipe[i]  <= r_vs_pipe[i-1];
          end
        end
      end

      assign w_act_d = r_act_pipe[COLOR_LATENCY-1];
      assign w_hs_d  = r_hs_pipe[COLOR_LATENCY-1];
      assign w_vs_d  = r_vs_pipe[COLOR_LATENCY-1];
    end
  endgenerate

  // Masking with delayed-active keeps don't-care blanking colour off the pins.
  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      VGA_R      <= 1'b0;
      VGA_G      <= 1'b0;
      VGA_B      <= 1'b0;
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      VGA_R      <= color[2] & w_act_d;
      VGA_G      <= color[1] & w_act_d;
      VGA_B      <= color[0] & w_act_d;
      VGA_HS     <= w_hs_d;
      VGA_VS     <= w_vs_d;
      frame_tick <= w_tick_next;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      r_frame_count <= '0;
    end else if (w_tick_next) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`endif

endmodule
`default_nettype wire
